// File: rtl/operand_prefixer_pkg.sv
// operand_prefixer_pkg
//   Shared definitions for the operand prefixer: instruction function codes,
//   nibble width and the state encoding exposed on the debug port.
package operand_prefixer_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [3:0] FN_PFIX = 4'h2;
    localparam logic [3:0] FN_LDC  = 4'h4;
    localparam logic [3:0] FN_NFIX = 4'h6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        FULL   = 2'd2
    } state_t;

    // Number of bits needed to count prefixes up to width/4-1 (at least 1).
    function automatic int depth_bits(input int width);
        return (width / NIBBLE_W > 1) ? $clog2(width / NIBBLE_W) : 1;
    endfunction

endpackage

// File: rtl/operand_prefixer_accum.sv
// prefix_accum
//   Combinational next-state for the prefix accumulator.
//   Ports:
//     oreg_i/depth_i/ovf_i : current accumulator, prefix depth, sticky overflow
//     fn_i/data_i          : function code and data nibble of the incoming byte
//     oreg_o/depth_o/ovf_o : values to load if the byte is an accepted prefix
//     is_prefix_o          : fn_i is a pfix or nfix code
module prefix_accum
    import operand_prefixer_pkg::*;
#(
    parameter int         WIDTH   = 16,
    parameter int         DEPTH_W = 2,
    parameter logic [3:0] PFIX_FN = FN_PFIX,
    parameter logic [3:0] NFIX_FN = FN_NFIX
) (
    input  logic [WIDTH-1:0]   oreg_i,
    input  logic [DEPTH_W-1:0] depth_i,
    input  logic               ovf_i,
    input  logic [3:0]         fn_i,
    input  logic [3:0]         data_i,
    output logic [WIDTH-1:0]   oreg_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               ovf_o,
    output logic               is_prefix_o
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(WIDTH / NIBBLE_W - 1);

    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] inverted;
    logic             at_max;

    assign merged   = oreg_i | {{(WIDTH-NIBBLE_W){1'b0}}, data_i};
    assign inverted = ~merged;
    assign at_max   = (depth_i == DEPTH_MAX);

    always_comb begin
        oreg_o      = oreg_i;
        depth_o     = depth_i;
        ovf_o       = ovf_i;
        is_prefix_o = 1'b0;
        if (fn_i == PFIX_FN) begin
            is_prefix_o = 1'b1;
            oreg_o      = merged << NIBBLE_W;
            if (at_max) ovf_o = 1'b1;
            else        depth_o = depth_i + 1'b1;
        end else if (fn_i == NFIX_FN) begin
            is_prefix_o = 1'b1;
            oreg_o      = inverted << NIBBLE_W;
            // Shifting out an all-ones nibble is just sign extension of a
            // negative operand, so only other values count as lost bits.
            if (at_max) begin
                if (inverted[WIDTH-1 -: NIBBLE_W] != 4'hF) ovf_o = 1'b1;
            end else begin
                depth_o = depth_i + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_prefixer.sv
// operand_prefixer
//   Accumulates pfix/nfix data nibbles into a WIDTH-bit operand and emits
//   {fn, operand, ovf} through a one-entry registered output on any other
//   function byte.
//   Ports:
//     CLK, RESET_N (async active-low), FLUSH (sync clear of all state)
//     IN_BYTE/IN_VALID/IN_READY : input byte stream, fn=[7:4], data=[3:0]
//     OUT_FN/OUT_OPERAND/OUT_OVF/OUT_VALID/OUT_READY : completed instruction
//     DBG_STATE : current controller state
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; valid never depends on ready, and the payload holds steady
//   while valid is high and ready is low.
module operand_prefixer
    import operand_prefixer_pkg::*;
#(
    parameter int         WIDTH   = 16,
    parameter logic [3:0] PFIX_FN = FN_PFIX,
    parameter logic [3:0] NFIX_FN = FN_NFIX
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             FLUSH,
    input  logic [7:0]       IN_BYTE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [3:0]       OUT_FN,
    output logic [WIDTH-1:0] OUT_OPERAND,
    output logic             OUT_OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output state_t           DBG_STATE
);

    localparam int DEPTH_W = depth_bits(WIDTH);

    logic [WIDTH-1:0]   oreg_q, oreg_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               is_prefix;
    state_t             state_q;
    logic [3:0]         out_fn_q;
    logic [WIDTH-1:0]   out_operand_q;
    logic               out_ovf_q;
    logic               out_valid_q;
    logic               accept;
    logic [3:0]         in_fn;
    logic [3:0]         in_data;

    assign in_fn   = IN_BYTE[7:4];
    assign in_data = IN_BYTE[3:0];

    // Ready when the output slot is empty or being drained this cycle.
    assign IN_READY = ~out_valid_q | OUT_READY;
    assign accept   = IN_VALID & IN_READY;

    prefix_accum #(
        .WIDTH   (WIDTH),
        .DEPTH_W (DEPTH_W),
        .PFIX_FN (PFIX_FN),
        .NFIX_FN (NFIX_FN)
    ) u_accum (
        .oreg_i      (oreg_q),
        .depth_i     (depth_q),
        .ovf_i       (ovf_q),
        .fn_i        (in_fn),
        .data_i      (in_data),
        .oreg_o      (oreg_d),
        .depth_o     (depth_d),
        .ovf_o       (ovf_d),
        .is_prefix_o (is_prefix)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            oreg_q        <= '0;
            depth_q       <= '0;
            ovf_q         <= 1'b0;
            state_q       <= IDLE;
            out_fn_q      <= '0;
            out_operand_q <= '0;
            out_ovf_q     <= 1'b0;
            out_valid_q   <= 1'b0;
        end else if (FLUSH) begin
            // Flush overrides any accept; the presented byte is dropped.
            oreg_q        <= '0;
            depth_q       <= '0;
            ovf_q         <= 1'b0;
            state_q       <= IDLE;
            out_fn_q      <= '0;
            out_operand_q <= '0;
            out_ovf_q     <= 1'b0;
            out_valid_q   <= 1'b0;
        end else if (accept && is_prefix) begin
            // A prefix is only accepted from FULL when the output drains.
            oreg_q      <= oreg_d;
            depth_q     <= depth_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b0;
            state_q     <= PREFIX;
        end else if (accept) begin
            out_fn_q      <= in_fn;
            out_operand_q <= oreg_q | {{(WIDTH-NIBBLE_W){1'b0}}, in_data};
            out_ovf_q     <= ovf_q;
            out_valid_q   <= 1'b1;
            oreg_q        <= '0;
            depth_q       <= '0;
            ovf_q         <= 1'b0;
            state_q       <= FULL;
        end else if (out_valid_q && OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
        end
    end

    assign OUT_FN      = out_fn_q;
    assign OUT_OPERAND = out_operand_q;
    assign OUT_OVF     = out_ovf_q;
    assign OUT_VALID   = out_valid_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_operand_prefixer.sv
module tb_operand_prefixer;
  import operand_prefixer_pkg::*;

  localparam int W = 16;
  localparam int MAX_DEPTH = W / 4 - 1;
  localparam int unsigned MASK = (32'd1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready;
  logic [3:0] out_fn;
  logic [W-1:0] out_operand;
  logic out_ovf;
  logic out_valid;
  state_t dbg_state;

  always #5 clk = ~clk;

  operand_prefixer #(.WIDTH(W)) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .FLUSH       (flush),
    .IN_BYTE     (in_byte),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .OUT_FN      (out_fn),
    .OUT_OPERAND (out_operand),
    .OUT_OVF     (out_ovf),
    .OUT_VALID   (out_valid),
    .OUT_READY   (out_ready),
    .DBG_STATE   (dbg_state)
  );

  // ---------------- reference model ----------------
  // Operand kept as a plain integer; prefix count and sticky overflow follow
  // the instruction-level rules directly.
  int unsigned m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 0;
  bit m_valid = 0;
  logic [3:0] m_fn = '0;
  logic [W-1:0] m_op = '0;
  bit m_movf = 0;
  logic [W+4:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_ovf = 0;
    m_valid = 0; m_fn = '0; m_op = '0; m_movf = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit ordy, input bit fl);
    bit acc;
    int unsigned t;
    int unsigned d;
    int unsigned top;
    acc = v && (!m_valid || ordy);
    if (fl) begin
      model_reset();
      return;
    end
    if (m_valid && ordy) m_valid = 0;
    if (acc) begin
      d = b[3:0];
      if (b[7:4] == 4'h2) begin
        t = m_acc | d;
        if (m_cnt >= MAX_DEPTH) m_ovf = 1; else m_cnt++;
        m_acc = (t * 16) & MASK;
      end else if (b[7:4] == 4'h6) begin
        t = (~(m_acc | d)) & MASK;
        top = t >> (W - 4);
        if (m_cnt >= MAX_DEPTH) begin
          if (top != 15) m_ovf = 1;
        end else begin
          m_cnt++;
        end
        m_acc = (t * 16) & MASK;
      end else begin
        m_valid = 1;
        m_fn = b[7:4];
        m_op = W'(m_acc | d);
        m_movf = m_ovf;
        exp_q.push_back({m_fn, m_op, m_movf});
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
    check("state_full", {31'd0, (dbg_state == FULL)}, {31'd0, m_valid});
    if (m_valid) begin
      check("out_fn", {28'd0, out_fn}, {28'd0, m_fn});
      check("out_operand", {16'd0, out_operand}, {16'd0, m_op});
      check("out_ovf", {31'd0, out_ovf}, {31'd0, m_movf});
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle's inputs at the falling edge, checks the outputs that
  // resulted from the previous rising edge, then advances the model.
  task automatic step(input bit v, input logic [7:0] b, input bit ordy, input bit fl);
    logic [W+4:0] got;
    @(negedge clk);
    in_valid = v; in_byte = b; out_ready = ordy; flush = fl;
    #1;
    compare_outputs();
    if (out_valid && out_ready && !fl) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        got = {out_fn, out_operand, out_ovf};
        check("sb_output", 32'(got), 32'(exp_q.pop_front()));
      end
    end
    model_step(v, b, ordy, fl);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] fn, input logic [W-1:0] op, input bit ovf);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_fn"}, {28'd0, out_fn}, {28'd0, fn});
    check({tag, "_op"}, {16'd0, out_operand}, {16'd0, op});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
  endtask

  task automatic expect_zero(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_fn"}, {28'd0, out_fn}, 32'd0);
    check({tag, "_op"}, {16'd0, out_operand}, 32'd0);
    check({tag, "_ovf"}, {31'd0, out_ovf}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
  endtask

  function automatic logic [7:0] rand_byte();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 40) return {4'h2, 4'($urandom_range(0, 15))};
    if (sel < 55) return {4'h6, 4'($urandom_range(0, 15))};
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    expect_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Positive prefix chain, result one cycle after the function byte.
    step(1, 8'h21, 1, 0);
    step(1, 8'h22, 1, 0);
    step(1, 8'h23, 1, 0);
    step(1, 8'h44, 1, 0);
    check("pchain_not_early", {31'd0, out_valid}, 32'd0);
    step(0, 8'h00, 1, 0);
    expect_out("pchain", 4'h4, 16'h1234, 0);

    // Negative prefixes.
    step(1, 8'h60, 1, 0);
    step(1, 8'h44, 1, 0);
    step(0, 8'h00, 1, 0);
    expect_out("nfix_a", 4'h4, 16'hFFF4, 0);
    step(1, 8'h61, 1, 0);
    step(1, 8'h40, 1, 0);
    step(0, 8'h00, 1, 0);
    expect_out("nfix_b", 4'h4, 16'hFFE0, 0);

    // Overflow then a clean instruction.
    step(1, 8'h21, 1, 0);
    step(1, 8'h22, 1, 0);
    step(1, 8'h23, 1, 0);
    step(1, 8'h24, 1, 0);
    step(1, 8'h45, 1, 0);
    step(1, 8'h47, 1, 0);
    expect_out("ovf", 4'h4, 16'h2345, 1);
    step(0, 8'h00, 1, 0);
    expect_out("ovf_next", 4'h4, 16'h0007, 0);

    // Backpressure: output frozen, then drained with no bubble.
    step(1, 8'h41, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h52, 0, 0);
      expect_out("bp_hold", 4'h4, 16'h0001, 0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    step(1, 8'h52, 1, 0);
    check("bp_ready_release", {31'd0, in_ready}, 32'd1);
    step(0, 8'h00, 1, 0);
    expect_out("bp_next", 4'h5, 16'h0002, 0);

    // Flush mid-prefix drops the concurrent function byte.
    step(1, 8'h21, 1, 0);
    step(1, 8'h22, 1, 0);
    step(1, 8'h43, 1, 1);
    step(0, 8'h00, 1, 0);
    check("flush_no_out", {31'd0, out_valid}, 32'd0);
    step(1, 8'h47, 1, 0);
    step(0, 8'h00, 1, 0);
    expect_out("flush_after", 4'h4, 16'h0007, 0);

    // Asynchronous reset mid-prefix.
    step(1, 8'h41, 0, 0);
    step(1, 8'h21, 1, 0);
    step(1, 8'h22, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    expect_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h47, 1, 0);
    step(0, 8'h00, 1, 0);
    expect_out("reset_after", 4'h4, 16'h0007, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 80, rand_byte(), $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 3);
    end
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
